// File: rtl/alu_rs_pkg.sv
// Shared widths, constants and opcode encoding for the ALU reservation station.
package alu_rs_pkg;

   localparam int DATA_WIDTH          = 32;
   localparam int ROB_TAG_WIDTH       = 5;
   localparam int INSIDE_OPCODE_WIDTH = 6;

   localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
   localparam logic [DATA_WIDTH-1:0]    ZERO_DATA    = '0;

   typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
      NOP  = 6'd0,
      ADD  = 6'd1,
      SUB  = 6'd2,
      ADDI = 6'd3,
      BEQ  = 6'd4,
      JAL  = 6'd5
   } inside_op_e;

   // A pending operand tag matches a bus only when the operand is still waiting;
   // an idle bus carries tag 0, which never matches a pending tag.
   function automatic logic tag_hit(input logic [ROB_TAG_WIDTH-1:0] tag,
                                    input logic [ROB_TAG_WIDTH-1:0] cdb_tag);
      return (tag != ZERO_TAG_ROB) && (tag == cdb_tag);
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Two lowest-index priority encoders: first free slot and first ready slot.
module rs_select #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  i_free_vec,
   input  logic [N-1:0]  i_ready_vec,
   output logic          o_free_found,
   output logic [IW-1:0] o_free_idx,
   output logic          o_ready_found,
   output logic [IW-1:0] o_ready_idx
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      o_free_found = 1'b0;
      o_free_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_free_vec[i]) begin
            o_free_found = 1'b1;
            o_free_idx   = IW'(i);
         end
      end
   end

   // Same lowest-index search over the ready vector.
   always_comb begin
      o_ready_found = 1'b0;
      o_ready_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_ready_vec[i]) begin
            o_ready_found = 1'b1;
            o_ready_idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the single ALU: buffers dispatched ops, snoops both
// CDBs for operand wakeup and issues one ready op per cycle on registered outputs.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_SIZE      = 16,
   parameter int RS_IDX_WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           in_clear,
   input  logic                           in_valid,
   input  logic [INSIDE_OPCODE_WIDTH-1:0] in_op,
   input  logic [DATA_WIDTH-1:0]          in_value1,
   input  logic [DATA_WIDTH-1:0]          in_value2,
   input  logic [ROB_TAG_WIDTH-1:0]       in_tag1,
   input  logic [ROB_TAG_WIDTH-1:0]       in_tag2,
   input  logic [DATA_WIDTH-1:0]          in_imm,
   input  logic [DATA_WIDTH-1:0]          in_pc,
   input  logic [ROB_TAG_WIDTH-1:0]       in_rob_tag,
   output logic                           out_full,
   input  logic [ROB_TAG_WIDTH-1:0]       cdb_alu_tag,
   input  logic [DATA_WIDTH-1:0]          cdb_alu_value,
   input  logic [ROB_TAG_WIDTH-1:0]       cdb_lsb_tag,
   input  logic [DATA_WIDTH-1:0]          cdb_lsb_value,
   output logic [INSIDE_OPCODE_WIDTH-1:0] out_op,
   output logic [DATA_WIDTH-1:0]          out_value1,
   output logic [DATA_WIDTH-1:0]          out_value2,
   output logic [DATA_WIDTH-1:0]          out_imm,
   output logic [DATA_WIDTH-1:0]          out_pc,
   output logic [ROB_TAG_WIDTH-1:0]       out_rob_tag
);

   logic [RS_SIZE-1:0]             r_busy;
   logic [INSIDE_OPCODE_WIDTH-1:0] r_op   [RS_SIZE];
   logic [DATA_WIDTH-1:0]          r_val1 [RS_SIZE];
   logic [DATA_WIDTH-1:0]          r_val2 [RS_SIZE];
   logic [ROB_TAG_WIDTH-1:0]       r_tag1 [RS_SIZE];
   logic [ROB_TAG_WIDTH-1:0]       r_tag2 [RS_SIZE];
   logic [DATA_WIDTH-1:0]          r_imm  [RS_SIZE];
   logic [DATA_WIDTH-1:0]          r_pc   [RS_SIZE];
   logic [ROB_TAG_WIDTH-1:0]       r_rob  [RS_SIZE];

   logic [RS_SIZE-1:0]      w_free_vec;
   logic [RS_SIZE-1:0]      w_ready_vec;
   logic                    w_free_found;
   logic                    w_ready_found;
   logic [RS_IDX_WIDTH-1:0] w_free_idx;
   logic [RS_IDX_WIDTH-1:0] w_ready_idx;
   logic                    w_insert;
   logic [DATA_WIDTH-1:0]   w_in_val1;
   logic [DATA_WIDTH-1:0]   w_in_val2;
   logic [ROB_TAG_WIDTH-1:0] w_in_tag1;
   logic [ROB_TAG_WIDTH-1:0] w_in_tag2;

   // An entry is ready once both operands are resolved; look only at registered tags
   // so a CDB wakeup issues no earlier than the following edge.
   for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
      assign w_ready_vec[gi] = r_busy[gi] && (r_tag1[gi] == ZERO_TAG_ROB)
                                          && (r_tag2[gi] == ZERO_TAG_ROB);
   end

   assign w_free_vec = ~r_busy;
   assign out_full   = &r_busy;
   assign w_insert   = in_valid && w_free_found;

   rs_select #(
      .N  (RS_SIZE),
      .IW (RS_IDX_WIDTH)
   ) u_select (
      .i_free_vec    (w_free_vec),
      .i_ready_vec   (w_ready_vec),
      .o_free_found  (w_free_found),
      .o_free_idx    (w_free_idx),
      .o_ready_found (w_ready_found),
      .o_ready_idx   (w_ready_idx)
   );

   // Bypass incoming operands from the CDBs so a result broadcast in the dispatch cycle is not missed.
   always_comb begin
      w_in_val1 = in_value1;
      w_in_tag1 = in_tag1;
      w_in_val2 = in_value2;
      w_in_tag2 = in_tag2;
      if (tag_hit(in_tag1, cdb_alu_tag)) begin
         w_in_val1 = cdb_alu_value;
         w_in_tag1 = ZERO_TAG_ROB;
      end else if (tag_hit(in_tag1, cdb_lsb_tag)) begin
         w_in_val1 = cdb_lsb_value;
         w_in_tag1 = ZERO_TAG_ROB;
      end
      if (tag_hit(in_tag2, cdb_alu_tag)) begin
         w_in_val2 = cdb_alu_value;
         w_in_tag2 = ZERO_TAG_ROB;
      end else if (tag_hit(in_tag2, cdb_lsb_tag)) begin
         w_in_val2 = cdb_lsb_value;
         w_in_tag2 = ZERO_TAG_ROB;
      end
   end

   // Entry array: wakeup of waiting operands, release of the issued slot, insert into the lowest free slot.
   // The issued slot is busy and the insert slot is free, so the two never collide.
   always_ff @(posedge clk) begin
      if (rst || in_clear) begin
         r_busy <= '0;
      end else if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i]) begin
               if (tag_hit(r_tag1[i], cdb_alu_tag)) begin
                  r_val1[i] <= cdb_alu_value;
                  r_tag1[i] <= ZERO_TAG_ROB;
               end else if (tag_hit(r_tag1[i], cdb_lsb_tag)) begin
                  r_val1[i] <= cdb_lsb_value;
                  r_tag1[i] <= ZERO_TAG_ROB;
               end
               if (tag_hit(r_tag2[i], cdb_alu_tag)) begin
                  r_val2[i] <= cdb_alu_value;
                  r_tag2[i] <= ZERO_TAG_ROB;
               end else if (tag_hit(r_tag2[i], cdb_lsb_tag)) begin
                  r_val2[i] <= cdb_lsb_value;
                  r_tag2[i] <= ZERO_TAG_ROB;
               end
            end
         end
         if (w_ready_found) begin
            r_busy[w_ready_idx] <= 1'b0;
         end
         if (w_insert) begin
            r_busy[w_free_idx] <= 1'b1;
            r_op[w_free_idx]   <= in_op;
            r_val1[w_free_idx] <= w_in_val1;
            r_val2[w_free_idx] <= w_in_val2;
            r_tag1[w_free_idx] <= w_in_tag1;
            r_tag2[w_free_idx] <= w_in_tag2;
            r_imm[w_free_idx]  <= in_imm;
            r_pc[w_free_idx]   <= in_pc;
            r_rob[w_free_idx]  <= in_rob_tag;
         end
      end
   end

   // Issue register toward the ALU: the selected entry's fields, or a NOP bubble.
   always_ff @(posedge clk) begin
      if (rst || in_clear) begin
         out_op      <= NOP;
         out_value1  <= ZERO_DATA;
         out_value2  <= ZERO_DATA;
         out_imm     <= ZERO_DATA;
         out_pc      <= ZERO_DATA;
         out_rob_tag <= ZERO_TAG_ROB;
      end else if (rdy) begin
         if (w_ready_found) begin
            out_op      <= r_op[w_ready_idx];
            out_value1  <= r_val1[w_ready_idx];
            out_value2  <= r_val2[w_ready_idx];
            out_imm     <= r_imm[w_ready_idx];
            out_pc      <= r_pc[w_ready_idx];
            out_rob_tag <= r_rob[w_ready_idx];
         end else begin
            out_op      <= NOP;
            out_value1  <= ZERO_DATA;
            out_value2  <= ZERO_DATA;
            out_imm     <= ZERO_DATA;
            out_pc      <= ZERO_DATA;
            out_rob_tag <= ZERO_TAG_ROB;
         end
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: reset, single issue, CDB wakeup/bypass, full, clear, rdy hold.
module tb_alu_rs;
   import alu_rs_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                           rst, rdy, in_clear, in_valid, out_full;
   logic [INSIDE_OPCODE_WIDTH-1:0] in_op, out_op;
   logic [DATA_WIDTH-1:0]          in_value1, in_value2, in_imm, in_pc;
   logic [ROB_TAG_WIDTH-1:0]       in_tag1, in_tag2, in_rob_tag, out_rob_tag;
   logic [ROB_TAG_WIDTH-1:0]       cdb_alu_tag, cdb_lsb_tag;
   logic [DATA_WIDTH-1:0]          cdb_alu_value, cdb_lsb_value;
   logic [DATA_WIDTH-1:0]          out_value1, out_value2, out_imm, out_pc;

   int n_checks = 0;
   int n_fail   = 0;

   alu_rs #(.RS_SIZE(16), .RS_IDX_WIDTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .in_clear      (in_clear),
      .in_valid      (in_valid),
      .in_op         (in_op),
      .in_value1     (in_value1),
      .in_value2     (in_value2),
      .in_tag1       (in_tag1),
      .in_tag2       (in_tag2),
      .in_imm        (in_imm),
      .in_pc         (in_pc),
      .in_rob_tag    (in_rob_tag),
      .out_full      (out_full),
      .cdb_alu_tag   (cdb_alu_tag),
      .cdb_alu_value (cdb_alu_value),
      .cdb_lsb_tag   (cdb_lsb_tag),
      .cdb_lsb_value (cdb_lsb_value),
      .out_op        (out_op),
      .out_value1    (out_value1),
      .out_value2    (out_value2),
      .out_imm       (out_imm),
      .out_pc        (out_pc),
      .out_rob_tag   (out_rob_tag)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [INSIDE_OPCODE_WIDTH-1:0] op,
                           input logic [DATA_WIDTH-1:0] v1, input logic [DATA_WIDTH-1:0] v2,
                           input logic [ROB_TAG_WIDTH-1:0] t1, input logic [ROB_TAG_WIDTH-1:0] t2,
                           input logic [ROB_TAG_WIDTH-1:0] rob);
      in_valid   = 1'b1;
      in_op      = op;
      in_value1  = v1;
      in_value2  = v2;
      in_tag1    = t1;
      in_tag2    = t2;
      in_rob_tag = rob;
      in_imm     = '0;
      in_pc      = '0;
   endtask

   task automatic idle_in();
      in_valid   = 1'b0;
      in_op      = NOP;
      in_value1  = '0;
      in_value2  = '0;
      in_tag1    = '0;
      in_tag2    = '0;
      in_rob_tag = '0;
      in_imm     = '0;
      in_pc      = '0;
   endtask

   task automatic cdb_idle();
      cdb_alu_tag   = '0;
      cdb_alu_value = '0;
      cdb_lsb_tag   = '0;
      cdb_lsb_value = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; in_clear = 1'b0;
      idle_in(); cdb_idle();
      tick(); tick();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (out_op !== NOP || out_full !== 1'b0 || out_rob_tag !== '0 || out_value1 !== '0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: op=%0d full=%0b rob=%0d v1=%0h, expected op=0 full=0 rob=0 v1=0",
                     c, out_op, out_full, out_rob_tag, out_value1);
         end
      end
   endtask

   task automatic test_single_issue();
      drive_op(ADD, 32'd5, 32'd7, '0, '0, 5'd3);
      in_imm = 32'h11; in_pc = 32'h40;
      tick();
      idle_in();
      n_checks++;
      if (out_op !== NOP) begin
         n_fail++;
         $display("FAIL single_no_same_cycle: op=%0d expected 0", out_op);
      end
      tick();
      n_checks++;
      if (out_op !== ADD || out_value1 !== 32'd5 || out_value2 !== 32'd7 || out_rob_tag !== 5'd3
          || out_imm !== 32'h11 || out_pc !== 32'h40) begin
         n_fail++;
         $display("FAIL single_issue: op=%0d v1=%0h v2=%0h rob=%0d imm=%0h pc=%0h, expected 1 5 7 3 11 40",
                  out_op, out_value1, out_value2, out_rob_tag, out_imm, out_pc);
      end
      $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
      tick();
      n_checks++;
      if (out_op !== NOP || out_rob_tag !== '0 || out_value1 !== '0 || out_pc !== '0) begin
         n_fail++;
         $display("FAIL single_bubble: op=%0d rob=%0d v1=%0h pc=%0h, expected all 0",
                  out_op, out_rob_tag, out_value1, out_pc);
      end
   endtask

   task automatic test_wakeup();
      drive_op(ADDI, 32'd0, 32'd2, 5'd4, '0, 5'd6);
      in_imm = 32'h20; in_pc = 32'h100;
      tick();
      idle_in();
      tick();
      n_checks++;
      if (out_op !== NOP) begin
         n_fail++;
         $display("FAIL wake_waiting: op=%0d expected 0", out_op);
      end
      cdb_alu_tag = 5'd4; cdb_alu_value = 32'h10;
      tick();
      cdb_idle();
      n_checks++;
      if (out_op !== NOP) begin
         n_fail++;
         $display("FAIL wake_not_same_edge: op=%0d expected 0", out_op);
      end
      tick();
      n_checks++;
      if (out_op !== ADDI || out_value1 !== 32'h10 || out_value2 !== 32'd2 || out_rob_tag !== 5'd6
          || out_imm !== 32'h20 || out_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL wake_issue: op=%0d v1=%0h v2=%0h rob=%0d imm=%0h pc=%0h, expected 3 10 2 6 20 100",
                  out_op, out_value1, out_value2, out_rob_tag, out_imm, out_pc);
      end
      $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
      // dispatch in the same cycle as both broadcasts: operands bypassed at insert
      drive_op(SUB, 32'd0, 32'd0, 5'd4, 5'd7, 5'd8);
      cdb_alu_tag = 5'd4; cdb_alu_value = 32'h33;
      cdb_lsb_tag = 5'd7; cdb_lsb_value = 32'h44;
      tick();
      idle_in(); cdb_idle();
      n_checks++;
      if (out_op !== NOP) begin
         n_fail++;
         $display("FAIL bypass_no_same_cycle: op=%0d expected 0", out_op);
      end
      tick();
      n_checks++;
      if (out_op !== SUB || out_value1 !== 32'h33 || out_value2 !== 32'h44 || out_rob_tag !== 5'd8) begin
         n_fail++;
         $display("FAIL bypass_issue: op=%0d v1=%0h v2=%0h rob=%0d, expected 2 33 44 8",
                  out_op, out_value1, out_value2, out_rob_tag);
      end
      $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
      tick();
   endtask

   task automatic test_full();
      for (int k = 0; k < 16; k++) begin
         drive_op(ADD, 32'd0, 32'(k), 5'd9, '0, 5'(16 + k));
         tick();
      end
      n_checks++;
      if (out_full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_set: full=%0b expected 1", out_full);
      end
      // a 17th, already-ready op must be dropped
      drive_op(JAL, 32'd1, 32'd1, '0, '0, 5'd1);
      tick();
      idle_in();
      n_checks++;
      if (out_full !== 1'b1 || out_op !== NOP) begin
         n_fail++;
         $display("FAIL full_drop: full=%0b op=%0d, expected full=1 op=0", out_full, out_op);
      end
      cdb_lsb_tag = 5'd9; cdb_lsb_value = 32'h99;
      tick();
      cdb_idle();
      for (int k = 0; k < 16; k++) begin
         tick();
         n_checks++;
         if (out_op !== ADD || out_rob_tag !== 5'(16 + k) || out_value1 !== 32'h99
             || out_value2 !== 32'(k)) begin
            n_fail++;
            $display("FAIL full_drain %0d: op=%0d rob=%0d v1=%0h v2=%0h, expected 1 %0d 99 %0h",
                     k, out_op, out_rob_tag, out_value1, out_value2, 16 + k, k);
         end
         $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
         if (k == 0) begin
            n_checks++;
            if (out_full !== 1'b0) begin
               n_fail++;
               $display("FAIL full_fall: full=%0b expected 0", out_full);
            end
         end
      end
      tick();
      n_checks++;
      if (out_op !== NOP || out_full !== 1'b0) begin
         n_fail++;
         $display("FAIL full_empty_after: op=%0d full=%0b rob=%0d, expected op=0 full=0",
                  out_op, out_full, out_rob_tag);
      end
   endtask

   task automatic test_clear();
      for (int k = 0; k < 7; k++) begin
         drive_op(ADD, 32'd0, 32'd0, 5'd9, '0, 5'(k + 1));
         tick();
      end
      drive_op(ADD, 32'd1, 32'd1, '0, '0, 5'd12);
      tick();
      // 8 busy, slot 7 ready: clear must suppress its issue and the new op
      in_clear = 1'b1;
      drive_op(ADD, 32'd1, 32'd2, '0, '0, 5'd5);
      cdb_lsb_tag = 5'd9; cdb_lsb_value = 32'h55;
      tick();
      in_clear = 1'b0;
      idle_in(); cdb_idle();
      n_checks++;
      if (out_op !== NOP || out_full !== 1'b0 || out_rob_tag !== '0) begin
         n_fail++;
         $display("FAIL clear_outputs: op=%0d full=%0b rob=%0d, expected all 0", out_op, out_full, out_rob_tag);
      end
      cdb_lsb_tag = 5'd9; cdb_lsb_value = 32'h55;
      tick();
      cdb_idle();
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (out_op !== NOP || out_rob_tag !== '0) begin
            n_fail++;
            $display("FAIL clear_empty cyc%0d: op=%0d rob=%0d, expected 0 0", c, out_op, out_rob_tag);
         end
      end
   endtask

   task automatic test_hold();
      drive_op(ADD, 32'd0, 32'd5, 5'd9, '0, 5'd21);
      tick();
      drive_op(ADD, 32'd0, 32'd6, 5'd9, '0, 5'd22);
      tick();
      drive_op(ADD, 32'd0, 32'd7, 5'd5, '0, 5'd23);
      tick();
      idle_in();
      cdb_lsb_tag = 5'd9; cdb_lsb_value = 32'hAB;
      tick();
      cdb_idle();
      tick();
      n_checks++;
      if (out_op !== ADD || out_rob_tag !== 5'd21 || out_value1 !== 32'hAB) begin
         n_fail++;
         $display("FAIL hold_pre: op=%0d rob=%0d v1=%0h, expected 1 21 ab", out_op, out_rob_tag, out_value1);
      end
      rdy = 1'b0;
      cdb_alu_tag = 5'd5; cdb_alu_value = 32'hCD;
      drive_op(ADD, 32'd3, 32'd3, '0, '0, 5'd30);
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (out_op !== ADD || out_rob_tag !== 5'd21 || out_value1 !== 32'hAB || out_value2 !== 32'd5
             || out_full !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_frozen cyc%0d: op=%0d rob=%0d v1=%0h v2=%0h full=%0b, expected 1 21 ab 5 0",
                     c, out_op, out_rob_tag, out_value1, out_value2, out_full);
         end
      end
      rdy = 1'b1;
      idle_in(); cdb_idle();
      tick();
      n_checks++;
      if (out_op !== ADD || out_rob_tag !== 5'd22 || out_value1 !== 32'hAB || out_value2 !== 32'd6) begin
         n_fail++;
         $display("FAIL hold_resume: op=%0d rob=%0d v1=%0h v2=%0h, expected 1 22 ab 6",
                  out_op, out_rob_tag, out_value1, out_value2);
      end
      $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
      tick();
      n_checks++;
      if (out_op !== NOP || out_rob_tag !== '0) begin
         n_fail++;
         $display("FAIL hold_no_capture: op=%0d rob=%0d, expected 0 0", out_op, out_rob_tag);
      end
      cdb_alu_tag = 5'd5; cdb_alu_value = 32'hEE;
      tick();
      cdb_idle();
      tick();
      n_checks++;
      if (out_op !== ADD || out_rob_tag !== 5'd23 || out_value1 !== 32'hEE || out_value2 !== 32'd7) begin
         n_fail++;
         $display("FAIL hold_late_wake: op=%0d rob=%0d v1=%0h v2=%0h, expected 1 23 ee 7",
                  out_op, out_rob_tag, out_value1, out_value2);
      end
      $display("issue op=%0d rob=%0d v1=%0h v2=%0h", out_op, out_rob_tag, out_value1, out_value2);
      tick();
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_wakeup();
      test_full();
      test_clear();
      test_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
